// File: rtl/rom_reader.sv
// ---------------------------------------------------------------------------
// rom_reader
// Sequential read controller for a small combinational ROM. A start command
// with a non-zero length walks the ROM from base for len words (address wraps
// modulo the ROM depth), registers each word and offers it downstream on a
// valid/ready handshake. A one-cycle done pulse marks command completion.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, base, len  command strobe (taken only in IDLE), first address,
//                     word count 0..2^ADDR_W
//   busy, done        command in progress / one-cycle completion pulse
//   rom_addr          address to ROM
//   rom_data          ROM data, combinational from rom_addr
//   dout, dout_valid, dout_ready, dout_last
//                     downstream word stream, last flags final word
//   checksum          XOR of words handed off in the current command
//                     (only with ROM_READER_CHECKSUM_EN defined)
//
// Optional feature macro: ROM_READER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module rom_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, OUT} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    state_t          state, state_nxt;
    logic [ADDR_W:0] remaining;
    logic            accept;    // non-empty command taken this cycle
    logic            zero_cmd;  // empty command: only a done pulse
    logic            hs;        // downstream handshake this cycle

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_cmd  = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        zero_cmd  = 1'b1;
                    end
                end
            end
            FETCH: state_nxt = OUT;
            OUT: begin
                if (dout_valid && dout_ready) begin
                    hs        = 1'b1;
                    state_nxt = dout_last ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rom_addr   <= '0;
            remaining  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            done <= zero_cmd || (hs && dout_last);
            if (accept) begin
                rom_addr  <= base;
                remaining <= len;
                busy      <= 1'b1;
            end
            // rom_addr was stable all through FETCH, so rom_data is settled here
            if (state == FETCH) begin
                dout       <= rom_data;
                dout_valid <= 1'b1;
                dout_last  <= (remaining == CNT_ONE);
            end
            if (hs) begin
                dout_valid <= 1'b0;
                if (dout_last) begin
                    dout_last <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    // truncating add gives the wrap back to address 0
                    rom_addr  <= rom_addr + ADDR_ONE;
                    remaining <= remaining - CNT_ONE;
                end
            end
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    // Cleared on any taken command (an empty one included) and frozen
    // between the done pulse and the next command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 checksum <= '0;
        else if (accept || zero_cmd) checksum <= '0;
        else if (hs)                 checksum <= checksum ^ dout;
    end
`endif

endmodule

// File: tb/tb_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_reader
// Scoreboard bench for rom_reader with a 4-entry ROM model (4,C,6,7). Each
// command pushes its expected words (data, last flag, address) into a queue;
// a monitor pops and compares on every downstream handshake.
// ---------------------------------------------------------------------------
module tb_rom_reader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, dout_valid, dout_last;
    logic              dout_ready = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data, dout;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] rom [4] = '{4'h4, 4'hC, 4'h6, 4'h7};
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    rom_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last)
`ifdef ROM_READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   last_hs_edge = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_burst(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_t e;
            e.addr = ADDR_W'((b + i) % 4);
            e.data = rom[e.addr];
            e.last = (i == l - 1);
            q.push_back(e);
        end
    endtask

    task automatic start_cmd(input int b, input int l);
        base  = ADDR_W'(b);
        len   = (ADDR_W+1)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns in the cycle where done is seen; checks it follows the last handshake.
    task automatic wait_done(input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        chk("done_latency", cyc, last_hs_edge);
    endtask

    // Monitor: handshake happens on the coming edge when valid and ready both
    // hold here (inputs are driven earlier in the same half cycle).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", dout_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("dout", dout, e.data);
                    chk("dout_last", dout_last, e.last);
                    chk("rom_addr", rom_addr, e.addr);
                    hs_cnt++;
                    if (e.last) last_hs_edge = cyc + 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hs0;

        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        rst_n = 1'b1;
        tick();

        // full sweep from 0, ready held high
        push_burst(0, 4);
        start_cmd(0, 4);
        chk("acc_busy", busy, 1);
        chk("acc_valid", dout_valid, 0);
        chk("acc_addr", rom_addr, 0);
        tick();
        chk("first_valid", dout_valid, 1);
        wait_done(20);
        chk("sweep_busy_off", busy, 0);
        chk("sweep_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("sweep_checksum", checksum, 4'h9);
`endif
        tick();
        chk("done_one_cycle", done, 0);

        // wrap 3 -> 0
        push_burst(3, 2);
        start_cmd(3, 2);
        chk("wrap_start_addr", rom_addr, 3);
        wait_done(20);
        chk("wrap_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("wrap_checksum", checksum, 4'h3);
`endif
        tick();

        // stall on word C for 5 cycles
        dout_ready = 1'b0;
        push_burst(1, 3);
        start_cmd(1, 3);
        n = 0;
        while (dout_valid !== 1'b1 && n < 5) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_dout", dout, 4'hC);
            chk("stall_valid", dout_valid, 1);
            tick();
        end
        dout_ready = 1'b1;
        wait_done(20);
        chk("stall_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("stall_checksum", checksum, 4'hD);
`endif
        tick();

        // empty command
        start_cmd(0, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_valid", dout_valid, 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("len0_checksum", checksum, 0);
`endif
        tick();
        chk("len0_done_off", done, 0);
        chk("len0_valid2", dout_valid, 0);
        tick();
        chk("len0_valid3", dout_valid, 0);

        // start while busy is ignored
        hs0 = hs_cnt;
        push_burst(2, 4);
        start_cmd(2, 4);
        tick();
        start_cmd(0, 1);
        tick();
        start_cmd(1, 2);
        wait_done(40);
        chk("busy_start_words", hs_cnt - hs0, 4);
        chk("busy_start_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("busy_start_checksum", checksum, 4'h9);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_start_idle_valid", dout_valid, 0);
            chk("busy_start_idle_busy", busy, 0);
        end

        // reset while a word is held in OUT
        hs0 = hs_cnt;
        push_burst(0, 4);
        start_cmd(0, 4);
        n = 0;
        while (hs_cnt - hs0 < 2 && n < 20) begin tick(); n++; end
        chk("mid_rst_two_words", hs_cnt - hs0, 2);
        dout_ready = 1'b0;
        tick();
        chk("mid_rst_pending", dout_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", rom_addr, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_last", dout_last, 0);
        q.delete();
        tick(); tick();
        chk("mid_rst_no_done", done, 0);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        tick();
        push_burst(2, 1);
        start_cmd(2, 1);
        wait_done(20);
        chk("post_rst_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("post_rst_checksum", checksum, 4'h6);
`endif
        tick();

        // start in the done cycle
        push_burst(0, 1);
        start_cmd(0, 1);
        wait_done(20);
        push_burst(1, 1);
        start_cmd(1, 1);
        chk("done_cycle_busy", busy, 1);
        chk("done_cycle_done_off", done, 0);
        wait_done(20);
        chk("done_cycle_q_empty", q.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
        chk("done_cycle_checksum", checksum, 4'hC);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
